// File: rtl/vram_writer.sv
// vram_writer: command-driven pixel writer and buffer filler for a double-buffered 32x32 VRAM.
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_color : command handshake and payload
//   frame_done            : end-of-frame pulse from the display driver
//   use_secondary_buffer  : front-buffer select (1 = buffer 1)
//   vram_wraddress/vram_data/vram_wren : VRAM write port
//   busy                  : high whenever a command is in progress
module vram_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [5:0]  cmd_color,
    input  logic        frame_done,
    output logic        use_secondary_buffer,
    output logic [10:0] vram_wraddress,
    output logic [31:0] vram_data,
    output logic        vram_wren,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WRITE, FILL, SWAP_WAIT} state_t;
    state_t      state, state_n;
    logic [9:0]  fill_cnt, fill_cnt_n;
    logic [10:0] addr_n;
    logic [31:0] data_n;
    logic        wren_n, sec_n;
    assign cmd_ready = state == IDLE;
    assign busy      = ~cmd_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            fill_cnt             <= '0;
            vram_wraddress       <= '0;
            vram_data            <= '0;
            vram_wren            <= 1'b0;
            use_secondary_buffer <= 1'b0;
        end else begin
            state                <= state_n;
            fill_cnt             <= fill_cnt_n;
            vram_wraddress       <= addr_n;
            vram_data            <= data_n;
            vram_wren            <= wren_n;
            use_secondary_buffer <= sec_n;
        end
    end
    // Address/data registers hold their value unless a write is launched; the back-buffer bit is
    // latched into the address at acceptance, so a fill stays in one buffer.
    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        addr_n     = vram_wraddress;
        data_n     = vram_data;
        wren_n     = 1'b0;
        sec_n      = use_secondary_buffer;
        case (state)
            IDLE: if (cmd_valid) begin
                state_n = cmd_op == 2'b00 ? WRITE : cmd_op == 2'b01 ? FILL : cmd_op == 2'b10 ? SWAP_WAIT : IDLE;
                if (!cmd_op[1]) begin
                    wren_n     = 1'b1;
                    addr_n     = {~use_secondary_buffer, cmd_op[0] ? 10'd0 : {cmd_y, cmd_x}};
                    data_n     = {26'b0, cmd_color};
                    fill_cnt_n = '0;
                end
            end
            WRITE: state_n = IDLE;
            FILL: if (&fill_cnt) begin
                state_n = IDLE;
            end else begin
                fill_cnt_n = fill_cnt + 10'd1;
                wren_n     = 1'b1;
                addr_n     = {vram_wraddress[10], fill_cnt + 10'd1};
            end
            SWAP_WAIT: if (frame_done) begin
                state_n = IDLE;
                sec_n   = ~use_secondary_buffer;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
